alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue controller sequencing one ALU operation at a time onto the four execution units: add, sub, mul, div.
- Accepts an opcode plus rs1/rs2 operands over a valid/ready handshake and pulses a one-hot start to the selected unit.
- Holds operands stable until that unit signals done, then returns the captured result over a second valid/ready handshake.
- Sits between decode/register-read and the arithmetic units; replaces ad-hoc per-unit operand routing with registered, held operands.

Parameters:
- W, 16, operand/result width.
- TIMEOUT, 255, max WAIT cycles before abort (used only with the optional feature); must fit 8 bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- in_opcode  input  2  00 add, 01 sub, 10 mul, 11 div.
- in_rs1  input  W  operand 1.
- in_rs2  input  W  operand 2.
- unit_start  output  4  one-hot start pulse; bit i = opcode i.
- op_rs1  output  W  operand 1 to units.
- op_rs2  output  W  operand 2 to units.
- unit_done  input  4  per-unit completion strobe.
- unit_result  input  4*W  unit i result in bits [i*W +: W].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  W  captured result.
- out_opcode  output  2  opcode of the returned result.
- out_err  output  1  result aborted by timeout.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; unit_start, op_rs1, op_rs2, out_valid, out_result, out_opcode, out_err, busy all 0.
  - in_ready = (state==IDLE) && !rst.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch opcode_q, rs1_q, rs2_q; go to START.
- START (exactly 1 cycle):
  - unit_start = 1<<opcode_q.
  - op_rs1/op_rs2 = rs1_q/rs2_q; operands held unchanged through WAIT.
  - Go to WAIT.
- WAIT:
  - unit_start=0.
  - On unit_done[opcode_q]=1: capture unit_result slice opcode_q into out_result; out_opcode=opcode_q; go to RESP.
  - unit_done bits for non-selected units are ignored.
  - Done is sampled only in WAIT; units assert done no earlier than the cycle after start.
- RESP:
  - out_valid=1; out_result, out_opcode, out_err held stable until out_ready.
  - On out_valid && out_ready: out_valid=0 next cycle; go to IDLE.
- Latency: request accepted at edge 0 → start high in cycle 1 → done earliest cycle 2 → out_valid earliest cycle 3.
- Throughput: one outstanding op; no new request accepted until the response handshake completes. There is no IDLE bypass, so a new accept occurs at the earliest one cycle after the response handshake.
- op_rs1/op_rs2 return to 0 in IDLE.
- Simultaneous done bits for several units: only opcode_q's bit is honoured.
- Reset mid-operation (any state): return to IDLE next edge; unit_start drops; no out_valid generated. A late unit_done arriving after reset is ignored.
- out_ready held high: response completes in the single RESP cycle.
- out_ready low: RESP persists indefinitely; in_ready stays 0.

Optional Feature:
- Macro: ALU_ISSUE_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on entering WAIT, incremented each WAIT cycle.
  - If it reaches TIMEOUT with no done: go to RESP with out_result=0, out_err=1.
  - A done arriving in the same cycle the counter reaches TIMEOUT wins: normal result, out_err=0.
  - out_err clears when the response handshake completes.
- Undefined: no counter; WAIT lasts until done; out_err tied 0.

Test Plan:
- Add, single-cycle unit: rst 2 cycles, then opcode=00, rs1=0x0005, rs2=0x0003, done next cycle with result 0x0008, out_ready=1 → unit_start=0001 for one cycle; out_valid cycle 3; out_result=0x0008, out_opcode=00.
- Div, multi-cycle unit: opcode=11, rs1=0x0064, rs2=0x0005, done after 17 cycles with result 0x0014 → op_rs1/op_rs2 stable all 17 cycles; in_ready=0 throughout; out_result=0x0014.
- Spurious done: opcode=10, unit_done=0001 pulsed in WAIT, then 0100 with result 0x0030 → first strobe ignored; out_result=0x0030.
- Backpressure: out_ready=0 for 5 cycles during RESP with a new in_valid pending → out_valid and out_result held; in_ready=0; second op accepted only after the response handshake.
- Reset mid-WAIT: rst for 1 cycle during a mul op → next cycle IDLE, out_valid=0, busy=0; late done ignored; subsequent sub 0x0009-0x0004 returns 0x0005.
- Timeout (ALU_ISSUE_TIMEOUT_EN, TIMEOUT=8): no done → out_valid after 8 WAIT cycles with out_result=0x0000, out_err=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU op at a time to the add/sub/mul/div units, holds operands until
// the selected unit reports done, then returns the result. Define ALU_ISSUE_TIMEOUT_EN to add a WAIT timeout.
module alu_issue_ctrl #(
  parameter int W = 16
`ifdef ALU_ISSUE_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_opcode,
  input  logic [W-1:0]   in_rs1,
  input  logic [W-1:0]   in_rs2,
  output logic [3:0]     unit_start,
  output logic [W-1:0]   op_rs1,
  output logic [W-1:0]   op_rs2,
  input  logic [3:0]     unit_done,
  input  logic [4*W-1:0] unit_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_result,
  output logic [1:0]     out_opcode,
  output logic           out_err,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid, once raised, holds its payload stable until that transfer occurs.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     opcode_q, opcode_d;
  logic [3:0]     unit_start_q, unit_start_d;
  logic [W-1:0]   op_rs1_q, op_rs1_d;
  logic [W-1:0]   op_rs2_q, op_rs2_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_result_q, out_result_d;
  logic [1:0]     out_opcode_q, out_opcode_d;
  logic           out_err_q, out_err_d;
  logic           busy_q, busy_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
`endif

  assign in_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    unit_start_d = 4'b0000;
    op_rs1_d     = op_rs1_q;
    op_rs2_d     = op_rs2_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_opcode_d = out_opcode_q;
    out_err_d    = out_err_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          // Operands go straight into the held operand flops so the units see them during START.
          opcode_d     = in_opcode;
          op_rs1_d     = in_rs1;
          op_rs2_d     = in_rs2;
          unit_start_d = 4'b0001 << in_opcode;
          state_d      = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      S_WAIT: begin
        if (unit_done[opcode_q]) begin
          out_result_d = unit_result[opcode_q*W +: W];
          out_opcode_d = opcode_q;
          out_err_d    = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        // A done in the same cycle as the final count takes priority over the abort.
        else if (wait_cnt_q == WAIT_LAST) begin
          out_result_d = '0;
          out_opcode_d = opcode_q;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          op_rs1_d    = '0;
          op_rs2_d    = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= 2'b00;
      unit_start_q <= 4'b0000;
      op_rs1_q     <= '0;
      op_rs2_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= 2'b00;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      unit_start_q <= unit_start_d;
      op_rs1_q     <= op_rs1_d;
      op_rs2_q     <= op_rs2_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opcode_q <= out_opcode_d;
      out_err_q    <= out_err_d;
      busy_q       <= busy_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign unit_start = unit_start_q;
  assign op_rs1     = op_rs1_q;
  assign op_rs2     = op_rs2_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_opcode = out_opcode_q;
  assign out_err    = out_err_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table of directed ops with emulated units, plus hand-written
// backpressure, reset-mid-operation and long-wait/timeout sequences.
module tb_alu_issue_ctrl;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_opcode;
  logic [W-1:0]   in_rs1, in_rs2;
  logic [3:0]     unit_start;
  logic [W-1:0]   op_rs1, op_rs2;
  logic [3:0]     unit_done;
  logic [4*W-1:0] unit_result;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [1:0]     out_opcode;
  logic           out_err;
  logic           busy;
  logic [1:0]     dbg_state;

  alu_issue_ctrl #(
    .W(W)
`ifdef ALU_ISSUE_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .unit_start(unit_start), .op_rs1(op_rs1), .op_rs2(op_rs2),
    .unit_done(unit_done), .unit_result(unit_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_opcode(out_opcode), .out_err(out_err), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           delay;
    logic [3:0]   spur;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a unit result bus with junk in every slice except the selected one.
  task automatic drive_result(input logic [1:0] op, input logic [W-1:0] val);
    unit_result = {4{~val}};
    unit_result[op*W +: W] = val;
  endtask

  // Full transaction with out_ready high; spur bits pulse on non-selected units while waiting.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int delay, input logic [3:0] spur, input logic [W-1:0] exp);
    logic [W-1:0] want;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_opcode = op; in_rs1 = a; in_rs2 = b; out_ready = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0; in_rs1 = ~a; in_rs2 = ~b;
    chk("unit_start", unit_start, 4'b0001 << op);
    chk("op_rs1_start", op_rs1, a);
    chk("op_rs2_start", op_rs2, b);
    chk("busy_start", busy, 1);
    chk("dbg_state_start", dbg_state, 1);
    chk("in_ready_start", in_ready, 0);
    tick();
    chk("unit_start_wait", unit_start, 0);
    for (int i = 1; i <= delay; i++) begin
      if (i == delay) begin
        unit_done = spur | (4'b0001 << op);
        drive_result(op, exp);
      end else begin
        unit_done = spur;
        unit_result = {4{~exp}};
      end
      chk("op_rs1_held", op_rs1, a);
      chk("op_rs2_held", op_rs2, b);
      chk("out_valid_wait", out_valid, 0);
      chk("in_ready_wait", in_ready, 0);
      tick();
    end
    unit_done = 4'b0000;
    want = exp_q.pop_front();
    chk("out_valid_resp", out_valid, 1);
    chk("out_result", out_result, want);
    chk("out_opcode", out_opcode, op);
    chk("out_err", out_err, 0);
    tick();
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("in_ready_after", in_ready, 1);
    chk("op_rs1_cleared", op_rs1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 16'h0005, 16'h0003, 1, 4'b0000, 16'h0008};
`ifdef ALU_ISSUE_TIMEOUT_EN
    vecs[1] = '{2'd3, 16'h0064, 16'h0005, 8, 4'b0000, 16'h0014};
`else
    vecs[1] = '{2'd3, 16'h0064, 16'h0005, 17, 4'b0000, 16'h0014};
`endif
    vecs[2] = '{2'd2, 16'h000C, 16'h0004, 3, 4'b0001, 16'h0030};
    vecs[3] = '{2'd1, 16'h0009, 16'h0004, 2, 4'b1001, 16'h0005};
    vecs[4] = '{2'd0, 16'hFFFF, 16'h0001, 1, 4'b0000, 16'h0000};
    vecs[5] = '{2'd3, 16'h0007, 16'h0002, 4, 4'b0111, 16'h0003};

    rst = 1'b1; in_valid = 1'b0; in_opcode = 2'b00; in_rs1 = '0; in_rs2 = '0;
    unit_done = 4'b0000; unit_result = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_op_rs1", op_rs1, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].delay, vecs[v].spur, vecs[v].exp);

    // Backpressure: response stalls 5 cycles while a second request waits.
    out_ready = 1'b0;
    in_valid = 1'b1; in_opcode = 2'd0; in_rs1 = 16'h1000; in_rs2 = 16'h0234;
    tick();
    in_opcode = 2'd1; in_rs1 = 16'h0020; in_rs2 = 16'h0008;
    chk("bp_in_ready_start", in_ready, 0);
    tick();
    tick();
    unit_done = 4'b0001; drive_result(2'd0, 16'h1234);
    tick();
    unit_done = 4'b0000; unit_result = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_out_result_held", out_result, 16'h1234);
      chk("bp_out_opcode_held", out_opcode, 0);
      chk("bp_in_ready_low", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_out_valid_last", out_valid, 1);
    tick();
    chk("bp_out_valid_drop", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_start", unit_start, 4'b0010);
    chk("bp_second_rs1", op_rs1, 16'h0020);
    tick();
    unit_done = 4'b0010; drive_result(2'd1, 16'h0018);
    tick();
    unit_done = 4'b0000;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_result", out_result, 16'h0018);
    chk("bp_second_opcode", out_opcode, 1);
    tick();
    chk("bp_second_done", out_valid, 0);

    // Reset in the middle of a mul wait, then a late done that must be ignored.
    in_valid = 1'b1; in_opcode = 2'd2; in_rs1 = 16'h0003; in_rs2 = 16'h0007;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_unit_start", unit_start, 0);
    chk("mid_rst_op_rs1", op_rs1, 0);
    chk("mid_rst_state", dbg_state, 0);
    unit_done = 4'b0100; drive_result(2'd2, 16'hBEEF);
    tick();
    unit_done = 4'b0000;
    chk("late_done_valid", out_valid, 0);
    chk("late_done_busy", busy, 0);
    tick();
    chk("late_done_valid2", out_valid, 0);
    run_op(2'd1, 16'h0009, 16'h0004, 1, 4'b0000, 16'h0005);

`ifdef ALU_ISSUE_TIMEOUT_EN
    // No done at all: abort after 8 WAIT cycles.
    in_valid = 1'b1; in_opcode = 2'd3; in_rs1 = 16'h0100; in_rs2 = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("to_out_valid_wait", out_valid, 0);
      tick();
    end
    chk("to_out_valid", out_valid, 1);
    chk("to_out_result", out_result, 16'h0000);
    chk("to_out_err", out_err, 1);
    chk("to_out_opcode", out_opcode, 3);
    tick();
    chk("to_out_valid_clear", out_valid, 0);
    chk("to_out_err_clear", out_err, 0);
`else
    // Long wait without any abort; the unit eventually answers.
    in_valid = 1'b1; in_opcode = 2'd3; in_rs1 = 16'h0100; in_rs2 = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      chk("long_out_valid_wait", out_valid, 0);
      chk("long_op_rs1_held", op_rs1, 16'h0100);
      tick();
    end
    unit_done = 4'b1000; drive_result(2'd3, 16'h00AB);
    tick();
    unit_done = 4'b0000;
    chk("long_out_valid", out_valid, 1);
    chk("long_out_result", out_result, 16'h00AB);
    chk("long_out_err", out_err, 0);
    tick();
    chk("long_out_valid_clear", out_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
